servo_status_rx: RTL and testbench
==================================

// Module: servo_status_rx
// PURPOSE
//  UART receive path of the bus-servo link: deserialises 8N1 bytes from rx, parses servo
//  status-response frames (FF FF ID LEN ERR POS_L POS_H CHK) and presents the decoded
//  ID/position/error with a one-cycle valid strobe. Lets the arm sequencer confirm each
//  servo's position after a command, instead of relying on a fixed delay.
// PARAMETERS
//  CLK_FREQ   50_000_000  sys_clk frequency, Hz
//  BAUD       115_200     line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (434 at defaults)
//  GAP_BITS   20          inter-byte silence, in bit times, that aborts a partial frame
// PORTS
//  sys_clk        in   1   system clock
//  sys_rst_n      in   1   reset, asynchronous, active-low
//  rx             in   1   UART line from servo bus, idle high, asynchronous
//  status_valid   out  1   1-cycle pulse: good frame decoded, status_* updated this cycle
//  status_id      out  8   servo ID of last good frame
//  status_pos     out  16  {POS_H,POS_L} of last good frame
//  status_err     out  8   servo ERR byte of last good frame
//  chk_err        out  1   1-cycle pulse: frame complete but checksum mismatch
//  frame_abort    out  1   1-cycle pulse: partial frame dropped (timeout, bad LEN, framing error)
//  busy           out  1   high while parser is past HDR1 (frame in progress)
// BEHAVIOUR
//  - Reset: all outputs 0, parser in HDR1, bit engine idle, gap counter 0.
//  - rx through 2-FF synchroniser before use.
//  - Bit engine: falling edge starts; start bit re-sampled at CLKS_PER_BIT/2, abort if high;
//    data sampled every CLKS_PER_BIT at mid-bit, LSB first; stop sampled mid-bit.
//    Stop=1 -> byte strobe (1 cycle); stop=0 -> framing error, no strobe, parser -> HDR1,
//    frame_abort pulses if parser was not in HDR1.
//  - Parser FSM (advances only on byte strobe):
//    HDR1: FF->HDR2, else stay.  HDR2: FF->ID, else HDR1.
//    ID: FF->stay (extra preamble), else latch id, ->LEN.
//    LEN: 04->ERR, else frame_abort, ->HDR1.
//    ERR->POSL->POSH->CHK, latching each byte.  CHK: compare, ->HDR1.
//  - Checksum: sum = ID+LEN+ERR+POS_L+POS_H, modulo 256 (8-bit wrap); expect CHK = ~sum.
//    Match -> status_* load and status_valid pulse; mismatch -> chk_err pulse, status_* hold.
//  - Latency: status_valid/chk_err asserted the cycle after the CHK byte strobe.
//  - status_* hold last good frame indefinitely; never cleared except by reset.
//  - Gap timeout: counter runs while parser != HDR1 and the bit engine is idle; cleared on
//    every byte strobe; reaching GAP_BITS*CLKS_PER_BIT -> frame_abort, parser -> HDR1.
//  - A new start bit arriving in the cycle of a pulse output is received normally; a
//    frame_abort and a new byte strobe in the same cycle: abort wins, byte is re-evaluated
//    from HDR1 (so FF can begin the next frame).
//  - Reset mid-frame: everything returns to reset state at once; no pulse generated.
//  - status_valid, chk_err and frame_abort are mutually exclusive in any cycle.
// STRUCTURE
//  - Shared package/header: frame constants HDR_BYTE=8'hFF, STATUS_LEN=8'h04, parser state
//    encodings; the command transmitter uses the same HDR_BYTE.
//  - Sub-module uart_rx_byte (sync, bit engine, framing error out) -> byte/strobe to parser;
//    parameters CLK_FREQ, BAUD. Parser, checksum and gap timer stay in this module.
// TESTING
//  1 FF FF 03 04 00 F4 01 03 at 115200 -> one status_valid; id=03, pos=0x01F4, err=00.
//  2 Same frame with CHK=04 -> chk_err pulse once, no status_valid, status_* keep test-1 values.
//  3 FF FF FF FF 05 04 20 E8 03 EB -> extra FF tolerated; valid, id=05, pos=0x03E8, err=20.
//  4 FF FF 03 then 25 bit times idle -> frame_abort once, busy falls; next full frame decodes.
//  5 FF FF 03 06 ... -> frame_abort on LEN byte, parser back to HDR1, no valid.
//  6 Byte with stop bit driven 0 mid-frame -> frame_abort; reset asserted mid-frame -> all 0.

Source files
------------

// File: rtl/servo_status_rx_pkg.sv
// rtl/servo_status_rx_pkg.sv - servo link frame constants, state encodings and checksum helper
package servo_status_rx_pkg;

  localparam logic [7:0] HDR_BYTE   = 8'hFF;
  localparam logic [7:0] STATUS_LEN = 8'h04;

  typedef enum logic [2:0] {
    PS_HDR1,
    PS_HDR2,
    PS_ID,
    PS_LEN,
    PS_ERR,
    PS_POSL,
    PS_POSH,
    PS_CHK
  } parser_state_t;

  typedef enum logic [1:0] {
    BS_IDLE,
    BS_START,
    BS_DATA,
    BS_STOP
  } bit_state_t;

  // The servo sends the one's complement of the 8-bit wrapped byte sum.
  function automatic logic [7:0] frame_chk(input logic [7:0] id, input logic [7:0] len,
                                           input logic [7:0] err, input logic [7:0] pos_l,
                                           input logic [7:0] pos_h);
    logic [7:0] sum;
    sum = id + len + err + pos_l + pos_h;
    return ~sum;
  endfunction

endpackage

// File: rtl/servo_status_rx_uart_rx_byte.sv
// rtl/servo_status_rx_uart_rx_byte.sv - 8N1 UART receive bit engine with input synchroniser
module uart_rx_byte #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_strobe,
  output logic       o_frame_err,
  output logic       o_idle
);
  import servo_status_rx_pkg::*;

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF_END = CW'(HALF_BIT - 1);

  logic          r_rx_meta, r_rx_sync, r_rx_prev;
  bit_state_t    r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [2:0]    r_bit_idx, w_bit_idx_nx;
  logic [7:0]    r_shift, w_shift_nx;
  logic          r_strobe, w_strobe_nx;
  logic          r_ferr, w_ferr_nx;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
      r_state   <= BS_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_strobe  <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_bit_idx <= w_bit_idx_nx;
      r_shift   <= w_shift_nx;
      r_strobe  <= w_strobe_nx;
      r_ferr    <= w_ferr_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt + 1'b1;
    w_bit_idx_nx = r_bit_idx;
    w_shift_nx   = r_shift;
    w_strobe_nx  = 1'b0;
    w_ferr_nx    = 1'b0;
    case (r_state)
      BS_IDLE: begin
        w_cnt_nx = '0;
        if (r_rx_prev && !r_rx_sync) w_state_nx = BS_START;
      end
      BS_START: begin
        // A start bit that is high again by mid-bit was a glitch.
        if (r_cnt == CNT_HALF_END) begin
          w_cnt_nx     = '0;
          w_bit_idx_nx = '0;
          w_state_nx   = r_rx_sync ? BS_IDLE : BS_DATA;
        end
      end
      BS_DATA: begin
        if (r_cnt == CNT_BIT_END) begin
          w_cnt_nx     = '0;
          w_shift_nx   = {r_rx_sync, r_shift[7:1]};
          w_bit_idx_nx = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_state_nx = BS_STOP;
        end
      end
      BS_STOP: begin
        if (r_cnt == CNT_BIT_END) begin
          w_cnt_nx    = '0;
          w_state_nx  = BS_IDLE;
          w_strobe_nx = r_rx_sync;
          w_ferr_nx   = !r_rx_sync;
        end
      end
      default: w_state_nx = BS_IDLE;
    endcase
  end

  assign o_byte      = r_shift;
  assign o_strobe    = r_strobe;
  assign o_frame_err = r_ferr;
  assign o_idle      = (r_state == BS_IDLE);

endmodule

// File: rtl/servo_status_rx.sv
// rtl/servo_status_rx.sv - servo status-response frame parser with checksum and gap timeout
module servo_status_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200,
  parameter int GAP_BITS = 20
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        rx,
  output logic        status_valid,
  output logic [7:0]  status_id,
  output logic [15:0] status_pos,
  output logic [7:0]  status_err,
  output logic        chk_err,
  output logic        frame_abort,
  output logic        busy
);
  import servo_status_rx_pkg::*;

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int GAP_LIMIT    = GAP_BITS * CLKS_PER_BIT;
  localparam int GW           = $clog2(GAP_LIMIT + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LIMIT - 1);

  logic [7:0]    w_byte;
  logic          w_strobe, w_frame_err, w_idle;
  parser_state_t r_state, w_state_nx, w_cur;
  logic [GW-1:0] r_gap_cnt;
  logic          w_gap_run, w_gap_hit;
  logic          w_valid, w_chk_fail, w_abort;
  logic [7:0]    r_id, r_err, r_pos_l, r_pos_h;
  logic          r_status_valid, r_chk_err, r_frame_abort;
  logic [7:0]    r_status_id, r_status_err;
  logic [15:0]   r_status_pos;

  uart_rx_byte #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_rx_byte (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .i_rx        (rx),
    .o_byte      (w_byte),
    .o_strobe    (w_strobe),
    .o_frame_err (w_frame_err),
    .o_idle      (w_idle)
  );

  assign w_gap_run = (r_state != PS_HDR1) && w_idle;
  assign w_gap_hit = w_gap_run && (r_gap_cnt == GAP_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= PS_HDR1;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // An abort forces the parser view back to HDR1 first, so a coincident byte restarts a frame.
  always_comb begin
    w_cur      = (w_gap_hit || w_frame_err) ? PS_HDR1 : r_state;
    w_state_nx = w_cur;
    w_abort    = w_gap_hit || (w_frame_err && (r_state != PS_HDR1));
    w_valid    = 1'b0;
    w_chk_fail = 1'b0;
    if (w_strobe) begin
      case (w_cur)
        PS_HDR1: if (w_byte == HDR_BYTE) w_state_nx = PS_HDR2;
        PS_HDR2: w_state_nx = (w_byte == HDR_BYTE) ? PS_ID : PS_HDR1;
        PS_ID:   if (w_byte != HDR_BYTE) w_state_nx = PS_LEN;
        PS_LEN: begin
          if (w_byte == STATUS_LEN) begin
            w_state_nx = PS_ERR;
          end else begin
            w_abort    = 1'b1;
            w_state_nx = PS_HDR1;
          end
        end
        PS_ERR:  w_state_nx = PS_POSL;
        PS_POSL: w_state_nx = PS_POSH;
        PS_POSH: w_state_nx = PS_CHK;
        PS_CHK: begin
          w_state_nx = PS_HDR1;
          if (w_byte == frame_chk(r_id, STATUS_LEN, r_err, r_pos_l, r_pos_h)) w_valid = 1'b1;
          else w_chk_fail = 1'b1;
        end
        default: w_state_nx = PS_HDR1;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_gap_cnt <= '0;
    end else if (w_strobe || (r_state == PS_HDR1) || w_gap_hit) begin
      r_gap_cnt <= '0;
    end else if (w_gap_run) begin
      r_gap_cnt <= r_gap_cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_id    <= '0;
      r_err   <= '0;
      r_pos_l <= '0;
      r_pos_h <= '0;
    end else if (w_strobe) begin
      case (w_cur)
        PS_ID:   if (w_byte != HDR_BYTE) r_id <= w_byte;
        PS_ERR:  r_err   <= w_byte;
        PS_POSL: r_pos_l <= w_byte;
        PS_POSH: r_pos_h <= w_byte;
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_status_valid <= 1'b0;
      r_chk_err      <= 1'b0;
      r_frame_abort  <= 1'b0;
      r_status_id    <= '0;
      r_status_pos   <= '0;
      r_status_err   <= '0;
    end else begin
      r_status_valid <= w_valid;
      r_chk_err      <= w_chk_fail;
      r_frame_abort  <= w_abort;
      if (w_valid) begin
        r_status_id  <= r_id;
        r_status_pos <= {r_pos_h, r_pos_l};
        r_status_err <= r_err;
      end
    end
  end

  assign status_valid = r_status_valid;
  assign chk_err      = r_chk_err;
  assign frame_abort  = r_frame_abort;
  assign status_id    = r_status_id;
  assign status_pos   = r_status_pos;
  assign status_err   = r_status_err;
  assign busy         = (r_state != PS_HDR1);

endmodule

// File: tb/tb_servo_status_rx.sv
// tb/tb_servo_status_rx.sv - self-checking bench for servo_status_rx
module tb_servo_status_rx;

  localparam int CLK_FREQ = 1_843_200;
  localparam int BAUD     = 115_200;
  localparam int GAP_BITS = 20;
  localparam int CPB      = CLK_FREQ / BAUD;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        rx        = 1'b1;
  logic        status_valid, chk_err, frame_abort, busy;
  logic [7:0]  status_id, status_err;
  logic [15:0] status_pos;

  always #5 sys_clk = ~sys_clk;

  servo_status_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .GAP_BITS (GAP_BITS)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .rx           (rx),
    .status_valid (status_valid),
    .status_id    (status_id),
    .status_pos   (status_pos),
    .status_err   (status_err),
    .chk_err      (chk_err),
    .frame_abort  (frame_abort),
    .busy         (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int mon_valid = 0, mon_chk = 0, mon_abort = 0, mon_overlap = 0;
  logic [7:0]  cap_id = '0, cap_err = '0;
  logic [15:0] cap_pos = '0;

  always @(negedge sys_clk) begin
    if (status_valid) begin
      mon_valid <= mon_valid + 1;
      cap_id    <= status_id;
      cap_pos   <= status_pos;
      cap_err   <= status_err;
    end
    if (chk_err)     mon_chk   <= mon_chk + 1;
    if (frame_abort) mon_abort <= mon_abort + 1;
    if (int'(status_valid) + int'(chk_err) + int'(frame_abort) > 1) mon_overlap <= mon_overlap + 1;
  end

  logic [7:0]  exp_id = '0, exp_err = '0;
  logic [15:0] exp_pos = '0;
  int base_v, base_c, base_a;
  logic [7:0] fq[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_chk(input int id, input int err, input int pl, input int ph);
    return 8'(255 - ((id + 4 + err + pl + ph) % 256));
  endfunction

  task automatic wait_bits(input int bits);
    repeat (bits * CPB) @(negedge sys_clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_bits(1);
    end
    rx = stop_bit;
    wait_bits(1);
    rx = 1'b1;
  endtask

  task automatic send_frame(input int gap_bits);
    foreach (fq[i]) begin
      send_byte(fq[i], 1'b1);
      wait_bits(gap_bits);
    end
  endtask

  task automatic mark();
    base_v = mon_valid;
    base_c = mon_chk;
    base_a = mon_abort;
  endtask

  task automatic expect_counts(input string tag, input int v, input int c, input int a);
    wait_bits(3);
    check_eq({tag, "_valid_cnt"}, 32'(mon_valid - base_v), 32'(v));
    check_eq({tag, "_chkerr_cnt"}, 32'(mon_chk - base_c), 32'(c));
    check_eq({tag, "_abort_cnt"}, 32'(mon_abort - base_a), 32'(a));
  endtask

  task automatic expect_status(input string tag);
    check_eq({tag, "_id"}, 32'(status_id), 32'(exp_id));
    check_eq({tag, "_pos"}, 32'(status_pos), 32'(exp_pos));
    check_eq({tag, "_err"}, 32'(status_err), 32'(exp_err));
  endtask

  task automatic expect_capture(input string tag);
    check_eq({tag, "_cap_id"}, 32'(cap_id), 32'(exp_id));
    check_eq({tag, "_cap_pos"}, 32'(cap_pos), 32'(exp_pos));
    check_eq({tag, "_cap_err"}, 32'(cap_err), 32'(exp_err));
  endtask

  task automatic expect_idle_outputs(input string tag);
    check_eq({tag, "_pulses"}, {29'd0, status_valid, chk_err, frame_abort}, 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_id"}, 32'(status_id), 32'd0);
    check_eq({tag, "_pos"}, 32'(status_pos), 32'd0);
    check_eq({tag, "_err"}, 32'(status_err), 32'd0);
  endtask

  initial begin
    repeat (5) @(negedge sys_clk);
    expect_idle_outputs("reset_hold");
    sys_rst_n = 1'b1;
    wait_bits(2);
    expect_idle_outputs("reset_release");

    mark();
    fq = '{8'hFF, 8'hFF, 8'h03, 8'h04, 8'h00, 8'hF4, 8'h01, 8'h03};
    send_frame(0);
    expect_counts("t1", 1, 0, 0);
    exp_id = 8'h03; exp_pos = 16'h01F4; exp_err = 8'h00;
    expect_status("t1");
    expect_capture("t1");

    mark();
    fq = '{8'hFF, 8'hFF, 8'h03, 8'h04, 8'h00, 8'hF4, 8'h01, 8'h04};
    send_frame(0);
    expect_counts("t2", 0, 1, 0);
    expect_status("t2");

    mark();
    fq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h05, 8'h04, 8'h20, 8'hE8, 8'h03, 8'hEB};
    send_frame(0);
    expect_counts("t3", 1, 0, 0);
    exp_id = 8'h05; exp_pos = 16'h03E8; exp_err = 8'h20;
    expect_status("t3");

    mark();
    fq = '{8'hFF, 8'hFF, 8'h03};
    send_frame(0);
    check_eq("t4_busy_mid", 32'(busy), 32'd1);
    wait_bits(25);
    check_eq("t4_busy_after", 32'(busy), 32'd0);
    expect_counts("t4", 0, 0, 1);
    mark();
    fq = '{8'hFF, 8'hFF, 8'h07, 8'h04, 8'h01, 8'h34, 8'h12, model_chk(7, 1, 'h34, 'h12)};
    send_frame(0);
    expect_counts("t4_next", 1, 0, 0);
    exp_id = 8'h07; exp_pos = 16'h1234; exp_err = 8'h01;
    expect_status("t4_next");

    mark();
    fq = '{8'hFF, 8'hFF, 8'h03, 8'h06};
    send_frame(0);
    check_eq("t5_busy", 32'(busy), 32'd0);
    wait_bits(25);
    expect_counts("t5", 0, 0, 1);

    mark();
    fq = '{8'hFF, 8'hFF, 8'h03};
    send_frame(0);
    send_byte(8'h04, 1'b0);
    check_eq("t6_busy", 32'(busy), 32'd0);
    expect_counts("t6_ferr", 0, 0, 1);
    expect_status("t6_ferr");

    fq = '{8'hFF, 8'hFF, 8'h03};
    send_frame(0);
    check_eq("t6_busy_pre_rst", 32'(busy), 32'd1);
    mark();
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    expect_idle_outputs("t6_rst");
    sys_rst_n = 1'b1;
    exp_id = '0; exp_pos = '0; exp_err = '0;
    wait_bits(25);
    expect_counts("t6_rst", 0, 0, 0);

    for (int n = 0; n < 12; n++) begin
      int id, er, pl, ph, pre, gap;
      logic bad;
      logic [7:0] ck;
      id  = $urandom_range(0, 254);
      er  = $urandom_range(0, 255);
      pl  = $urandom_range(0, 255);
      ph  = $urandom_range(0, 255);
      pre = $urandom_range(0, 2);
      gap = $urandom_range(0, 12);
      bad = ($urandom_range(0, 3) == 0);
      ck  = model_chk(id, er, pl, ph);
      if (bad) ck = ck ^ 8'($urandom_range(1, 255));
      fq.delete();
      fq.push_back(8'hFF);
      fq.push_back(8'hFF);
      for (int k = 0; k < pre; k++) fq.push_back(8'hFF);
      fq.push_back(8'(id));
      fq.push_back(8'h04);
      fq.push_back(8'(er));
      fq.push_back(8'(pl));
      fq.push_back(8'(ph));
      fq.push_back(ck);
      mark();
      send_frame(gap);
      if (bad) begin
        expect_counts("rnd_bad", 0, 1, 0);
      end else begin
        expect_counts("rnd_good", 1, 0, 0);
        exp_id = 8'(id); exp_err = 8'(er); exp_pos = 16'((ph << 8) | pl);
        expect_capture("rnd_good");
      end
      expect_status("rnd");
    end

    check_eq("pulse_exclusive", 32'(mon_overlap), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
